// File: rtl/mcdt_nch.sv
// mcdt_nch: NCH-channel data transfer block.
// Each channel owns a FIFO with a valid/ready write port and a free-space report.
// A fixed-priority or round-robin arbiter drains the FIFOs into one registered,
// channel-tagged output stream that honours downstream backpressure.
module mcdt_nch #(
    parameter int NCH    = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int IDW    = $clog2(NCH),
    parameter bit ARB_RR = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NCH-1:0]         ch_en_i,
    input  logic [NCH*DW-1:0]      ch_data_i,
    input  logic [NCH-1:0]         ch_valid_i,
    output logic [NCH-1:0]         ch_ready_o,
    output logic [NCH*(AW+1)-1:0]  ch_margin_o,
    output logic [DW-1:0]          mcdt_data_o,
    output logic                   mcdt_val_o,
    output logic [IDW-1:0]         mcdt_id_o,
    input  logic                   mcdt_ready_i
);

    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [IDW-1:0] LAST_CH = IDW'(NCH-1);

    // Per-channel storage and bookkeeping
    logic [DW-1:0] mem      [NCH][DEPTH];
    logic [AW-1:0] wr_ptr   [NCH];
    logic [AW-1:0] rd_ptr   [NCH];
    logic [AW:0]   count_q  [NCH];
    logic [AW:0]   count_d  [NCH];
    logic [AW:0]   margin_q [NCH];

    logic [NCH-1:0] full;
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;

    // Arbitration
    logic           slot_free;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] last_grant;
    logic [DW-1:0]  grant_data;

    // Full/empty come only from the registered count so a same-cycle pop never frees a slot
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            full[n]     = (count_q[n] == DEPTH_C);
            nonempty[n] = (count_q[n] != '0);
        end
    end

    assign ch_ready_o = rst_i ? '0 : (ch_en_i & ~full);
    assign push       = ch_valid_i & ch_ready_o;
    assign slot_free  = ~mcdt_val_o | mcdt_ready_i;

    // Pick the winning channel: rotating start after the last grant, or lowest index first
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < NCH; i++) begin
            if (ARB_RR) begin
                idx = (int'(last_grant) + 1 + i) % NCH;
            end else begin
                idx = i;
            end
            if (!grant_valid && nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    // Decode the grant into per-channel pops and fetch the head word of the winner
    always_comb begin
        pop        = '0;
        grant_data = '0;
        for (int n = 0; n < NCH; n++) begin
            if (grant_id == IDW'(n)) begin
                grant_data = mem[n][rd_ptr[n]];
                pop[n]     = slot_free & grant_valid;
            end
        end
    end

    // Next occupancy per channel; simultaneous push and pop leave it unchanged
    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            count_d[n] = count_q[n];
            case ({push[n], pop[n]})
                2'b10:   count_d[n] = count_q[n] + 1'b1;
                2'b01:   count_d[n] = count_q[n] - 1'b1;
                default: count_d[n] = count_q[n];
            endcase
        end
    end

    // Pointer, occupancy and margin registers; reset empties every FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NCH; n++) begin
                wr_ptr[n]   <= '0;
                rd_ptr[n]   <= '0;
                count_q[n]  <= '0;
                margin_q[n] <= DEPTH_C;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + 1'b1;
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + 1'b1;
                end
                count_q[n]  <= count_d[n];
                margin_q[n] <= DEPTH_C - count_d[n];
            end
        end
    end

    // FIFO storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NCH; n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= ch_data_i[n*DW +: DW];
            end
        end
    end

    // Round-robin pointer moves only when a grant actually happens
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= LAST_CH;
        end else if (slot_free && grant_valid) begin
            last_grant <= grant_id;
        end
    end

    // Output register: load on grant, drop valid when idle, hold under backpressure
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcdt_data_o <= '0;
            mcdt_id_o   <= '0;
            mcdt_val_o  <= 1'b0;
        end else if (slot_free) begin
            if (grant_valid) begin
                mcdt_data_o <= grant_data;
                mcdt_id_o   <= grant_id;
                mcdt_val_o  <= 1'b1;
            end else begin
                mcdt_val_o  <= 1'b0;
            end
        end
    end

    // Pack per-channel margins onto the flat output bus
    for (genvar gn = 0; gn < NCH; gn++) begin : g_margin
        assign ch_margin_o[gn*(AW+1) +: AW+1] = margin_q[gn];
    end

endmodule

// File: tb/tb_mcdt_nch.sv
// tb_mcdt_nch: scoreboard bench for mcdt_nch.
// Two instances (round-robin and fixed priority) share the same input stimulus.
// Accepted words go into per-channel model queues; a negedge monitor predicts
// arbitration from queue occupancy and compares every output the DUT presents.
module tb_mcdt_nch;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int IDW   = $clog2(NCH);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0]        ch_en = '1;
    logic [NCH-1:0]        ch_valid = '0;
    logic [NCH*DW-1:0]     ch_data = '0;
    logic                  mcdt_ready = 1'b1;

    logic [NCH-1:0]        rdy [2];
    logic [NCH*(AW+1)-1:0] mrg [2];
    logic [DW-1:0]         od  [2];
    logic                  ov  [2];
    logic [IDW-1:0]        oid [2];

    // Reference model state, index 0 = round robin, 1 = fixed priority
    logic [DW-1:0] mq [2][NCH][$];
    int            last_g [2];
    logic          pv [2];
    logic [DW-1:0] pd [2];
    int            pid [2];
    int            accepted [2];
    int            delivered [2];
    int            ch_delivered [2][NCH];
    bit            log_ids = 1'b0;
    int            id_log [2][$];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    mcdt_nch #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .ARB_RR(1'b1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .ch_en_i(ch_en), .ch_data_i(ch_data),
        .ch_valid_i(ch_valid), .ch_ready_o(rdy[0]), .ch_margin_o(mrg[0]),
        .mcdt_data_o(od[0]), .mcdt_val_o(ov[0]), .mcdt_id_o(oid[0]),
        .mcdt_ready_i(mcdt_ready)
    );

    mcdt_nch #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .ARB_RR(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst), .ch_en_i(ch_en), .ch_data_i(ch_data),
        .ch_valid_i(ch_valid), .ch_ready_o(rdy[1]), .ch_margin_o(mrg[1]),
        .mcdt_data_o(od[1]), .mcdt_val_o(ov[1]), .mcdt_id_o(oid[1]),
        .mcdt_ready_i(mcdt_ready)
    );

    task automatic compare_value(input string name, input int inst,
                                 input longint act, input longint exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s inst%0d: got 0x%0h, expected 0x%0h at %0t",
                     name, inst, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*DW-1:0] rand_data();
        logic [NCH*DW-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*DW +: DW] = $urandom;
        return r;
    endfunction

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic [NCH-1:0] en, input logic [NCH-1:0] valid,
                                 input logic [NCH*DW-1:0] data, input logic ready);
        @(posedge clk);
        #1;
        ch_en      = en;
        ch_valid   = valid;
        ch_data    = data;
        mcdt_ready = ready;
    endtask

    // Compare one instance against the model, then advance the model by one edge
    task automatic checkOutput(input int inst, input logic [NCH-1:0] r,
                               input logic [NCH*(AW+1)-1:0] m, input logic [DW-1:0] d,
                               input logic v, input logic [IDW-1:0] id);
        logic [NCH-1:0] exp_rdy;
        int g;
        int c;
        if (rst) begin
            compare_value("rst_val", inst, v, 0);
            compare_value("rst_data", inst, d, 0);
            compare_value("rst_id", inst, id, 0);
            compare_value("rst_ready", inst, r, 0);
            for (int k = 0; k < NCH; k++) begin
                compare_value($sformatf("rst_margin%0d", k), inst, m[k*(AW+1) +: AW+1], DEPTH);
                mq[inst][k].delete();
            end
            last_g[inst] = NCH - 1;
            pv[inst]     = 1'b0;
            pd[inst]     = '0;
            pid[inst]    = 0;
            return;
        end
        compare_value("out_val", inst, v, pv[inst]);
        compare_value("out_data", inst, d, pd[inst]);
        compare_value("out_id", inst, id, pid[inst]);
        for (int k = 0; k < NCH; k++) begin
            exp_rdy[k] = ch_en[k] && (mq[inst][k].size() < DEPTH);
            compare_value($sformatf("margin%0d", k), inst, m[k*(AW+1) +: AW+1],
                          DEPTH - mq[inst][k].size());
        end
        compare_value("ch_ready", inst, r, exp_rdy);
        if (v && mcdt_ready) begin
            delivered[inst]++;
            ch_delivered[inst][id]++;
            if (log_ids) id_log[inst].push_back(int'(id));
        end
        if (!v || mcdt_ready) begin
            g = -1;
            for (int k = 0; k < NCH; k++) begin
                c = (inst == 0) ? (last_g[inst] + 1 + k) % NCH : k;
                if (g < 0 && mq[inst][c].size() > 0) g = c;
            end
            if (g >= 0) begin
                pv[inst]     = 1'b1;
                pid[inst]    = g;
                pd[inst]     = mq[inst][g].pop_front();
                last_g[inst] = g;
            end else begin
                pv[inst] = 1'b0;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (ch_valid[k] && exp_rdy[k]) begin
                mq[inst][k].push_back(ch_data[k*DW +: DW]);
                accepted[inst]++;
            end
        end
    endtask

    // Monitor: sample both instances on the falling edge, away from the active edge
    always @(negedge clk) begin
        checkOutput(0, rdy[0], mrg[0], od[0], ov[0], oid[0]);
        checkOutput(1, rdy[1], mrg[1], od[1], ov[1], oid[1]);
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [NCH*DW-1:0] d;
        int snap_acc [2];
        int snap_del [2];
        int snap_ch1 [2];
        int exp_rr [12];
        int exp_fp [12];

        for (int i = 0; i < 2; i++) begin
            accepted[i]  = 0;
            delivered[i] = 0;
            for (int k = 0; k < NCH; k++) ch_delivered[i][k] = 0;
        end

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) applyStimulus('1, '0, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("idle_ready", i, rdy[i], 4'b1111);
            compare_value("idle_val", i, ov[i], 0);
            for (int k = 0; k < NCH; k++)
                compare_value($sformatf("idle_margin%0d", k), i, mrg[i][k*(AW+1) +: AW+1], 32);
        end

        // Single word on channel 2: visible after edge T+1, gone after T+2
        d = '0;
        d[2*DW +: DW] = 32'h00C0_0005;
        applyStimulus('1, 4'b0100, d, 1'b1);
        applyStimulus('1, 4'b0000, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare_value("lat_early_val", i, ov[i], 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("lat_val", i, ov[i], 1);
            compare_value("lat_data", i, od[i], 32'h00C0_0005);
            compare_value("lat_id", i, oid[i], 2);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare_value("lat_val_drop", i, ov[i], 0);

        // Backpressure burst until every FIFO is full, then drain
        for (int i = 0; i < 2; i++) begin
            snap_acc[i] = accepted[i];
            snap_del[i] = delivered[i];
        end
        repeat (40) applyStimulus('1, '1, rand_data(), 1'b0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("burst_ready", i, rdy[i], 0);
            for (int k = 0; k < NCH; k++)
                compare_value($sformatf("burst_margin%0d", k), i, mrg[i][k*(AW+1) +: AW+1], 0);
        end
        repeat (200) applyStimulus('1, '0, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("burst_accepts", i, accepted[i] - snap_acc[i], 129);
            compare_value("burst_drained", i, delivered[i] - snap_del[i], 129);
            for (int k = 0; k < NCH; k++)
                compare_value($sformatf("drain_margin%0d", k), i, mrg[i][k*(AW+1) +: AW+1], 32);
        end

        // Arbitration order with three words pre-filled per channel
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        id_log[0].delete();
        id_log[1].delete();
        log_ids = 1'b1;
        repeat (3) applyStimulus('1, '1, rand_data(), 1'b0);
        repeat (20) applyStimulus('1, '0, '0, 1'b1);
        @(negedge clk);
        log_ids = 1'b0;
        for (int j = 0; j < 12; j++) begin
            exp_rr[j] = j % 4;
            exp_fp[j] = j / 3;
        end
        compare_value("rr_count", 0, id_log[0].size(), 12);
        compare_value("fp_count", 1, id_log[1].size(), 12);
        for (int j = 0; j < 12; j++) begin
            compare_value($sformatf("rr_id%0d", j), 0,
                          (j < id_log[0].size()) ? id_log[0][j] : -1, exp_rr[j]);
            compare_value($sformatf("fp_id%0d", j), 1,
                          (j < id_log[1].size()) ? id_log[1][j] : -1, exp_fp[j]);
        end

        // Disabled channel still drains its queued words
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) snap_ch1[i] = ch_delivered[i][1];
        repeat (5) applyStimulus('1, 4'b0010, rand_data(), 1'b0);
        applyStimulus(4'b1101, 4'b0011, rand_data(), 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare_value("dis_ready1", i, rdy[i][1], 0);
        repeat (9) applyStimulus(4'b1101, 4'b0011, rand_data(), 1'b1);
        repeat (40) applyStimulus(4'b1101, 4'b0000, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            compare_value("dis_ch1_words", i, ch_delivered[i][1] - snap_ch1[i], 5);

        // Reset in the middle of a drain
        repeat (10) applyStimulus('1, 4'b0101, rand_data(), 1'b0);
        repeat (4) applyStimulus('1, 4'b0000, '0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("mid_rst_val", i, ov[i], 0);
            for (int k = 0; k < NCH; k++)
                compare_value($sformatf("mid_rst_margin%0d", k), i, mrg[i][k*(AW+1) +: AW+1], 32);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) snap_del[i] = delivered[i];
        repeat (10) applyStimulus('1, '0, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("post_rst_words", i, delivered[i] - snap_del[i], 0);
            compare_value("post_rst_val", i, ov[i], 0);
        end

        // Random traffic against the model, then a full drain
        for (int t = 0; t < 2000; t++) begin
            applyStimulus(NCH'($urandom | $urandom), NCH'($urandom), rand_data(),
                          ($urandom_range(0, 3) != 0));
        end
        repeat (300) applyStimulus('1, '0, '0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare_value("rand_final_val", i, ov[i], 0);
            compare_value("rand_delivered", i, delivered[i] > 0, 1);
            for (int k = 0; k < NCH; k++)
                compare_value($sformatf("rand_margin%0d", k), i, mrg[i][k*(AW+1) +: AW+1], 32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
